// File: rtl/ex_muldiv_iter.sv
// ex_muldiv_iter: iterative RV M-extension unit for the execute stage.
// Multiply retires MUL_BITS multiplier bits per cycle; divide is restoring,
// DIV_BITS quotient bits per cycle, MSB first. Divide-by-zero and signed
// overflow finish in one cycle. o_valid pulses for exactly one cycle per result.
// Optional feature macro: ARVI_MDU_REUSE_EN. It keeps the last divide's
// quotient and remainder so that the complementary op (DIV<->REM, DIVU<->REMU)
// on the same operands completes in one cycle.
module ex_muldiv_iter #(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 2,
    parameter int DIV_BITS = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_m_en,
    input  logic            i_kill,
    input  logic [2:0]      i_f3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic [XLEN-1:0] o_res,
    output logic            o_valid,
    output logic            o_stall,
    output logic            o_busy
);

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] MUL_ITERS = CNT_W'(XLEN / MUL_BITS);
    localparam logic [CNT_W-1:0] DIV_ITERS = CNT_W'(XLEN / DIV_BITS);
    localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   res_q;
    logic              valid_q;

    // operation context captured at accept
    logic              hi_q;        // MULH* returns the upper half
    logic              rem_sel_q;   // REM/REMU returns the remainder
    logic              res_neg_q;   // product / quotient must be negated
    logic              rem_neg_q;   // remainder takes the dividend sign

    // multiply datapath
    logic [2*XLEN-1:0] mul_acc_q;
    logic [2*XLEN-1:0] mcand_q;
    logic [XLEN-1:0]   mplier_q;
    logic [2*XLEN-1:0] pp_sum;
    logic [2*XLEN-1:0] prod_fix;

    // divide datapath
    logic [XLEN-1:0]   quo_q;       // dividend bits shift out, quotient bits shift in
    logic [XLEN-1:0]   prem_q;      // partial remainder
    logic [XLEN-1:0]   dvsr_q;
    logic [XLEN-1:0]   q_next;
    logic [XLEN-1:0]   r_next;
    logic [XLEN-1:0]   q_fix;
    logic [XLEN-1:0]   r_fix;

    // accept-time decode
    logic              dec_div;
    logic              dec_rem;
    logic              dec_a_signed;
    logic              dec_b_signed;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              div_special;
    logic [XLEN-1:0]   spec_q;
    logic [XLEN-1:0]   spec_r;

`ifdef ARVI_MDU_REUSE_EN
    logic              op_signed_q;
    logic [XLEN-1:0]   op_rs1_q;
    logic [XLEN-1:0]   op_rs2_q;
    logic              ru_valid_q;
    logic              ru_signed_q;
    logic              ru_rem_op_q;
    logic [XLEN-1:0]   ru_rs1_q;
    logic [XLEN-1:0]   ru_rs2_q;
    logic [XLEN-1:0]   ru_quo_q;
    logic [XLEN-1:0]   ru_rem_q;
    logic              ru_hit;
`endif

    // Decode funct3 into signedness, magnitudes and the one-cycle divide cases.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        dec_div      = i_f3[2];
        dec_rem      = i_f3[1];
        dec_a_signed = dec_div ? ~i_f3[0] : (i_f3[1:0] == 2'b01 || i_f3[1:0] == 2'b10);
        dec_b_signed = dec_div ? ~i_f3[0] : (i_f3[1:0] == 2'b01);
        a_neg        = dec_a_signed & i_rs1[XLEN-1];
        b_neg        = dec_b_signed & i_rs2[XLEN-1];
        a_mag        = a_neg ? -i_rs1 : i_rs1;
        b_mag        = b_neg ? -i_rs2 : i_rs2;
        spec_q       = '1;
        spec_r       = i_rs1;
        div_special  = 1'b0;
        if (i_rs2 == '0) begin
            div_special = 1'b1;
        end else if (dec_a_signed && i_rs1 == MOST_NEG && i_rs2 == '1) begin
            div_special = 1'b1;
            spec_q      = i_rs1;
            spec_r      = '0;
        end
    end

`ifdef ARVI_MDU_REUSE_EN
    // Stored divide result matches the complementary op on identical operands.
    always_comb begin
        ru_hit = ru_valid_q && dec_div && (ru_signed_q == dec_a_signed) &&
                 (ru_rs1_q == i_rs1) && (ru_rs2_q == i_rs2) && (ru_rem_op_q != dec_rem);
    end
`endif

    // One multiply step: add MUL_BITS shifted partial products, then sign fix-up.
    always_comb begin
        pp_sum = mul_acc_q;
        for (int j = 0; j < MUL_BITS; j++) begin
            if (mplier_q[j]) pp_sum = pp_sum + (mcand_q << j);
        end
        prod_fix = res_neg_q ? -pp_sum : pp_sum;
    end

    // One restoring-divide step: DIV_BITS quotient bits, MSB first, then sign fix-up.
    always_comb begin
        logic [XLEN:0]   r;
        logic [XLEN-1:0] q;
        r = {1'b0, prem_q};
        q = quo_q;
        for (int j = 0; j < DIV_BITS; j++) begin
            r = {r[XLEN-1:0], q[XLEN-1]};
            q = {q[XLEN-2:0], 1'b0};
            if (r >= {1'b0, dvsr_q}) begin
                r    = r - {1'b0, dvsr_q};
                q[0] = 1'b1;
            end
        end
        q_next = q;
        r_next = r[XLEN-1:0];
        q_fix  = res_neg_q ? -q_next : q_next;
        r_fix  = rem_neg_q ? -r_next : r_next;
    end

    // Control FSM with registered result and valid; kill beats accept and completion.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: only control state and the result register are reset; the
            // datapath registers are always reloaded at accept before they are read.
            state   <= S_IDLE;
            cnt     <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
`ifdef ARVI_MDU_REUSE_EN
            ru_valid_q <= 1'b0;
`endif
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the values from before this edge.
            valid_q <= 1'b0;
            if (i_kill) begin
                state <= S_IDLE;
                cnt   <= '0;
`ifdef ARVI_MDU_REUSE_EN
                ru_valid_q <= 1'b0;
`endif
            end else begin
                case (state)
                    S_IDLE: begin
                        if (i_m_en) begin
                            hi_q      <= |i_f3[1:0];
                            rem_sel_q <= dec_rem;
                            res_neg_q <= a_neg ^ b_neg;
                            rem_neg_q <= a_neg;
                            mul_acc_q <= '0;
                            mcand_q   <= {{XLEN{1'b0}}, a_mag};
                            mplier_q  <= b_mag;
                            quo_q     <= a_mag;
                            prem_q    <= '0;
                            dvsr_q    <= b_mag;
`ifdef ARVI_MDU_REUSE_EN
                            op_signed_q <= dec_a_signed;
                            op_rs1_q    <= i_rs1;
                            op_rs2_q    <= i_rs2;
`endif
                            if (dec_div && div_special) begin
                                res_q   <= dec_rem ? spec_r : spec_q;
                                valid_q <= 1'b1;
                                state   <= S_DONE;
`ifdef ARVI_MDU_REUSE_EN
                                ru_valid_q  <= 1'b1;
                                ru_signed_q <= dec_a_signed;
                                ru_rem_op_q <= dec_rem;
                                ru_rs1_q    <= i_rs1;
                                ru_rs2_q    <= i_rs2;
                                ru_quo_q    <= spec_q;
                                ru_rem_q    <= spec_r;
                            end else if (ru_hit) begin
                                res_q   <= dec_rem ? ru_rem_q : ru_quo_q;
                                valid_q <= 1'b1;
                                state   <= S_DONE;
`endif
                            end else if (dec_div) begin
                                cnt   <= DIV_ITERS;
                                state <= S_DIV;
                            end else begin
                                cnt   <= MUL_ITERS;
                                state <= S_MUL;
                            end
                        end
                    end
                    S_MUL: begin
                        mul_acc_q <= pp_sum;
                        mcand_q   <= mcand_q << MUL_BITS;
                        mplier_q  <= mplier_q >> MUL_BITS;
                        cnt       <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            res_q   <= hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
                            valid_q <= 1'b1;
                            state   <= S_DONE;
`ifdef ARVI_MDU_REUSE_EN
                            ru_valid_q <= 1'b0;
`endif
                        end
                    end
                    S_DIV: begin
                        quo_q  <= q_next;
                        prem_q <= r_next;
                        cnt    <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            res_q   <= rem_sel_q ? r_fix : q_fix;
                            valid_q <= 1'b1;
                            state   <= S_DONE;
`ifdef ARVI_MDU_REUSE_EN
                            ru_valid_q  <= 1'b1;
                            ru_signed_q <= op_signed_q;
                            ru_rem_op_q <= rem_sel_q;
                            ru_rs1_q    <= op_rs1_q;
                            ru_rs2_q    <= op_rs2_q;
                            ru_quo_q    <= q_fix;
                            ru_rem_q    <= r_fix;
`endif
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_res   = res_q;
    assign o_valid = valid_q;
    assign o_busy  = (state != S_IDLE);
    assign o_stall = i_m_en & ~valid_q & ~i_kill;

endmodule

// File: tb/tb_ex_muldiv_iter.sv
// Testbench for ex_muldiv_iter (XLEN=32, MUL_BITS=2, DIV_BITS=1).
// A driver issues directed operations and pushes hand-computed results and
// latencies into a scoreboard; a monitor pops and compares on every o_valid.
module tb_ex_muldiv_iter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            m_en;
    logic            kill;
    logic [2:0]      f3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] res;
    logic            valid;
    logic            stall;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct {
        string           nm;
        logic [XLEN-1:0] res;
        int              lat;
        int              acc;
    } exp_t;

    exp_t sb[$];

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

`ifdef ARVI_MDU_REUSE_EN
    localparam int REUSE_LAT = 1;
`else
    localparam int REUSE_LAT = 33;
`endif

    ex_muldiv_iter #(.XLEN(32), .MUL_BITS(2), .DIV_BITS(1)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_m_en  (m_en),
        .i_kill  (kill),
        .i_f3    (f3),
        .i_rs1   (rs1),
        .i_rs2   (rs2),
        .o_res   (res),
        .o_valid (valid),
        .o_stall (stall),
        .o_busy  (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every result pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", valid, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.nm, "_res"}, res, e.res);
                check({e.nm, "_lat"}, cyc - e.acc + 1, e.lat);
            end
        end
    end

    // Issue one op, hold i_m_en until the result, scramble operands while busy.
    task automatic issue(input string nm, input logic [2:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int lat);
        int  stall_low;
        bit  seen;
        @(negedge clk);
        m_en = 1'b1;
        f3   = op;
        rs1  = a;
        rs2  = b;
        sb.push_back('{nm, exp, lat, cyc + 1});
        stall_low = 0;
        seen      = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            rs1 = ~a;
            rs2 = b ^ 32'h5A5A_A5A5;
            if (valid) begin
                seen = 1'b1;
                check({nm, "_stall_on_valid"}, stall, 1'b0);
            end else if (!stall) begin
                stall_low++;
            end
        end
        m_en = 1'b0;
        check({nm, "_stall_while_busy_low_cycles"}, stall_low, 0);
        if (!seen) check({nm, "_timeout"}, valid, 1'b1);
    endtask

    initial begin
        rst  = 1'b1;
        m_en = 1'b0;
        kill = 1'b0;
        f3   = '0;
        rs1  = '0;
        rs2  = '0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_res", res, 32'h0);
        check("rst_valid", valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        m_en = 1'b1;
        #1;
        check("rst_stall_eq", stall, 1'b1);
        @(negedge clk);
        m_en = 1'b0;
        rst  = 1'b0;

        // multiplies
        issue("mul_7xm3",     F_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 17);
        issue("mulh_min",     F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 17);
        issue("mulhu_max",    F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 17);
        issue("mulhsu_m1x2",  F_MULHSU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 17);

        // divides
        issue("div_m7_2",     F_DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
        issue("rem_m7_2",     F_REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, REUSE_LAT);
        issue("rem_20_m6",    F_REM,    32'd20,       32'hFFFF_FFFA, 32'd2,        33);
        issue("divu_big_16",  F_DIVU,   32'hFFFF_FFFF, 32'd16,       32'h0FFF_FFFF, 33);

        // one-cycle special cases
        issue("divu_by0",     F_DIVU,   32'h1234,     32'h0,        32'hFFFF_FFFF, 1);
        issue("remu_by0",     F_REMU,   32'h1234,     32'h0,        32'h1234,      1);
        issue("div_ovf",      F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        issue("rem_ovf",      F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);

        // kill during a divide at iteration 10
        @(negedge clk);
        m_en = 1'b1;
        f3   = F_DIV;
        rs1  = 32'd100;
        rs2  = 32'd7;
        repeat (10) @(negedge clk);
        check("kill_busy_before", busy, 1'b1);
        kill = 1'b1;
        #1;
        check("kill_stall", stall, 1'b0);
        @(negedge clk);
        kill = 1'b0;
        m_en = 1'b0;
        check("kill_busy", busy, 1'b0);
        check("kill_valid", valid, 1'b0);
        check("kill_res_kept", res, 32'h0);
        repeat (40) @(negedge clk);
        issue("mul_3x5", F_MUL, 32'd3, 32'd5, 32'd15, 17);

        // reset in the middle of a multiply
        @(negedge clk);
        m_en = 1'b1;
        f3   = F_MULHU;
        rs1  = 32'hDEAD_BEEF;
        rs2  = 32'h1234_5678;
        repeat (6) @(negedge clk);
        rst  = 1'b1;
        m_en = 1'b0;
        @(negedge clk);
        check("midrst_res", res, 32'h0);
        check("midrst_valid", valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        issue("mul_max_lo", F_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 17);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
